tradeoff_feeder: RTL
====================

# tradeoff_feeder

Upstream sequencer for the 12-bit tradeoff search core. It buffers incoming W operands in a small FIFO and presents one operand at a time to the core, holding it stable. It ignores the core's `found` output for a settle window, then captures N on the first cycle `found` is high. Each result is returned on a valid/ready port, checked against an expected N, and counted, which gives a synthesizable replacement for the bench's pass/fail bookkeeping.

## Interface
Parameters:
- `W_BITS`, 25, operand width
- `N_BITS`, 13, result width
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `SETTLE`, 2, cycles after a new W during which `core_found` is ignored (≥1)
- `TIMEOUT`, 8192, max WAIT cycles before forcing a timeout result
- `EXPECT_N`, 4095, reference N for the error check

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_w`  in  W_BITS  operand
- `in_valid`  in  1  operand offered
- `in_ready`  out  1  FIFO not full
- `core_w`  out  W_BITS  operand driven to the search core, registered
- `core_found`  in  1  core result-valid level
- `core_n`  in  N_BITS  core result
- `res_w`  out  W_BITS  operand belonging to the result
- `res_n`  out  N_BITS  captured N
- `res_err`  out  1  `res_n != EXPECT_N` or timeout
- `res_timeout`  out  1  result forced by timeout
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts
- `total_cnt`  out  16  results produced, saturating at 0xFFFF
- `err_cnt`  out  16  results with `res_err`=1, saturating
- `busy`  out  1  FSM not in IDLE

## Operation
- **FIFO**
  - Push when `in_valid & in_ready`.
  - `in_ready = (count != DEPTH)`, combinational from the count.
  - Pop happens only in IDLE.
  - Push and pop in the same cycle: count is unchanged and both take effect.
  - Pointers wrap modulo DEPTH.
- **FSM states: IDLE, SETTLE, WAIT, OUT.**
- **IDLE**
  - If the FIFO is non-empty: pop the head into `core_w`, load the settle counter with SETTLE−1, clear the timeout counter, go to SETTLE.
  - Otherwise stay in IDLE; `core_w` keeps its last value.
- **SETTLE**
  - `core_found` is ignored.
  - When the settle counter is 0, go to WAIT; otherwise decrement.
- **WAIT**
  - If `core_found`==1: set `res_w`=`core_w`, `res_n`=`core_n`, `res_timeout`=0, `res_err`=(`core_n` != EXPECT_N). Go to OUT.
  - Else if the timeout counter == TIMEOUT−1: set `res_n`=0, `res_timeout`=1, `res_err`=1. Go to OUT.
  - Else increment the timeout counter.
  - On either exit to OUT, increment `total_cnt`, and `err_cnt` if `res_err`, both saturating.
- **OUT**
  - `res_valid`=1; all `res_*` outputs held stable.
  - When `res_ready`=1: `res_valid`→0 on that edge, go to IDLE.
  - A new pop can occur on the following edge at the earliest, so there is one IDLE cycle between results.
- **Width rules**
  - Timeout counter width is $clog2(TIMEOUT).
  - The N compare is N_BITS wide, with EXPECT_N zero-extended.
- **Reset (asynchronous, any state, including mid-WAIT)**
  - FIFO emptied; FSM returns to IDLE.
  - `core_w`, `res_w`, `res_n`, `res_err`, `res_timeout`, `res_valid`, `total_cnt`, `err_cnt` all go to 0; `busy`=0.
  - `in_ready`=1 immediately after reset.
  - An in-flight operand is discarded and not counted.

## Timing
- Push accepted at edge k into an empty FIFO with the FSM in IDLE:
  - pop and `core_w` update at edge k+1
  - SETTLE occupies edges k+2 … k+1+SETTLE
  - earliest `found` sample at edge k+2+SETTLE, so `res_valid` is high after that edge
  - minimum latency is SETTLE+2 cycles from push to `res_valid`
- Timeout result: `res_valid` rises exactly TIMEOUT WAIT cycles after entering WAIT.
- `core_w` changes only on the IDLE→SETTLE edge, so it is stable for the whole search.
- `res_valid` never drops without `res_ready`.
- Counters update on the same edge that `res_valid` rises.
- Throughput with `res_ready` tied high and `found` immediate: one result per SETTLE+3 cycles.

## Test plan
- **Single operand, SETTLE=2.**
  - Stimulus: push `in_w`=16769025, model asserts `core_found` with `core_n`=4095 two cycles after `core_w` changes.
  - Required: `res_valid` rises, `res_w`=16769025, `res_n`=4095, `res_err`=0, `total_cnt`=1, `err_cnt`=0.
- **Stale found.**
  - Stimulus: hold `core_found`=1 continuously from the previous result; push a new W.
  - Required: nothing captured during the 2 SETTLE cycles; capture on the first WAIT cycle.
  - Latency is exactly 4 cycles from push to `res_valid`.
- **Mismatch.**
  - Stimulus: model returns `core_n`=4094.
  - Required: `res_err`=1, `err_cnt` increments by 1, `res_timeout`=0.
- **Timeout.**
  - Stimulus: TIMEOUT=16, `core_found` held 0.
  - Required: `res_valid` after 16 WAIT cycles, `res_n`=0, `res_timeout`=1, `res_err`=1.
- **Backpressure and FIFO full.**
  - Stimulus: push 6 operands back-to-back with `res_ready`=0.
  - Required: 1 operand in flight and 4 buffered; `in_ready` drops after the 5th accept, 6th held off.
  - Release `res_ready`: results emerge in push order, and `total_cnt` reaches 6 once the 6th is accepted and processed.
- **Reset mid-WAIT.**
  - Stimulus: assert `rst` asynchronously (between clock edges) while in WAIT with 2 operands buffered.
  - Required: `res_valid`=0, counters 0, `in_ready`=1, `busy`=0 immediately.
  - No result is emitted after release until a new push.

Source files
------------

// File: rtl/tradeoff_feeder.sv
// ---------------------------------------------------------------------------
// tradeoff_feeder
//
// Upstream sequencer for the tradeoff search core. Operands are buffered in a
// small FIFO and handed to the core one at a time. core_w is held stable for
// the whole search. The core's found flag is ignored for a settle window after
// each new operand. N is captured on the first WAIT cycle that found is high,
// or a timeout result is forced. Results go out on a valid/ready port and are
// counted: total results, and results whose N mismatched or timed out.
//
// Ports
//   clk, rst      single clock; asynchronous active-high reset
//   in_w/in_valid/in_ready         operand push port (ready = FIFO not full)
//   core_w                         registered operand driven to the core
//   core_found/core_n              core result level and value
//   res_w/res_n/res_err/res_timeout/res_valid/res_ready
//                                  result port, fields held while valid
//   total_cnt/err_cnt              saturating 16-bit result counters
//   busy                           sequencer not idle
// ---------------------------------------------------------------------------
module tradeoff_feeder #(
  parameter int W_BITS   = 25,
  parameter int N_BITS   = 13,
  parameter int DEPTH    = 4,
  parameter int SETTLE   = 2,
  parameter int TIMEOUT  = 8192,
  parameter int EXPECT_N = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_BITS-1:0] in_w,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W_BITS-1:0] core_w,
  input  logic              core_found,
  input  logic [N_BITS-1:0] core_n,
  output logic [W_BITS-1:0] res_w,
  output logic [N_BITS-1:0] res_n,
  output logic              res_err,
  output logic              res_timeout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       total_cnt,
  output logic [15:0]       err_cnt,
  output logic              busy
);

  localparam int AW = (DEPTH > 1)   ? $clog2(DEPTH)   : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (SETTLE > 1)  ? $clog2(SETTLE)  : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);
  localparam logic [SW-1:0]     SETTLE_LD = SW'(SETTLE - 1);
  localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [N_BITS-1:0] EXP_N     = N_BITS'(EXPECT_N);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT, S_OUT} state_t;

  state_t state, state_d;

  // ------------------------------------------------------------------ FIFO
  logic [W_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop;

  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid & in_ready;

  // Storage carries no reset: entries are only read once count says valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_w;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------------ FSM state
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (count != '0)          state_d = S_SETTLE;
      S_SETTLE: if (settle_cnt == '0)     state_d = S_WAIT;
      S_WAIT:   if (core_found || to_hit) state_d = S_OUT;
      S_OUT:    if (res_ready)            state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- FSM outputs
  logic cap;       // leaving WAIT with a result this edge
  logic cap_err;   // error flag of the result being captured

  always_comb begin
    pop       = 1'b0;
    cap       = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        pop  = (count != '0);
      end
      S_WAIT:  cap       = core_found | to_hit;
      S_OUT:   res_valid = 1'b1;
      default: ;
    endcase
    // A found result wins over a timeout landing on the same cycle.
    cap_err = core_found ? (core_n != EXP_N) : 1'b1;
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_w      <= '0;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      res_w       <= '0;
      res_n       <= '0;
      res_err     <= 1'b0;
      res_timeout <= 1'b0;
      total_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      // core_w only moves on the IDLE->SETTLE edge, so it is stable for the
      // full settle + wait window the core is searching.
      if (pop) begin
        core_w     <= mem[rd_ptr];
        settle_cnt <= SETTLE_LD;
        to_cnt     <= '0;
      end

      if (state == S_SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - SW'(1);

      if (state == S_WAIT && !cap)
        to_cnt <= to_cnt + TW'(1);

      if (cap) begin
        res_w       <= core_w;
        res_n       <= core_found ? core_n : '0;
        res_timeout <= ~core_found;
        res_err     <= cap_err;
        if (total_cnt != 16'hFFFF)
          total_cnt <= total_cnt + 16'd1;
        if (cap_err && err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule
